ti_arbiter: RTL
===============

// Module: ti_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single ti_req/ti_gnt port of the TI controller among NUM_REQ requesters.
//  Each requester is a state-transfer or PR agent. The winner's request is forwarded upstream and ti_gnt is routed back to it.
//  Arbitration is held until the upstream PR completes (pr_done), so exactly one requester owns the transfer at a time.
//  Sits between the requester agents and the TI controller. pr_done is shared with the controller.
// PARAMETERS
//  NUM_REQ      4    number of requesters (>=1)
//  ID_W         2    owner index width, equal to clog2(NUM_REQ); minimum 1
//  GNT_TIMEOUT  1024 cycles allowed in REQ before the sticky timeout flag sets; 0 disables the check
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous, active-high reset
//  req          in   NUM_REQ  per-requester request; held high until its gnt is seen, then dropped when done
//  gnt          out  NUM_REQ  one-hot grant to the owning requester
//  done         out  NUM_REQ  one-cycle pulse to the owner when its transfer completes
//  ti_req       out  1        request to the TI controller
//  ti_gnt       in   1        grant from the TI controller
//  pr_done      in   1        PR/transfer completion pulse
//  busy         out  1        high in any state other than IDLE
//  owner_id     out  ID_W     index of the current owner; valid while busy
//  err_timeout  out  1        sticky flag: GNT_TIMEOUT expired in REQ; cleared only by rst
// BEHAVIOUR
//  Reset values: state=IDLE, gnt=0, done=0, ti_req=0, busy=0, owner_id=0, rr_ptr=0, err_timeout=0, timer=0.
//  FSM states (2-bit): IDLE, REQ, GRANTED, WAIT_DONE.
//  IDLE: if |req, pick the first asserted bit searching upward from rr_ptr with wrap-around.
//    Register the winner into owner_id and go to REQ on the next clock. Decision latency is 1 cycle from req to ti_req.
//  REQ: ti_req=1. ti_req is never withdrawn in this state, even if the owner drops req, because the controller requires it held until grant.
//    On ti_gnt=1 go to GRANTED. timer counts up while in REQ.
//    When timer reaches GNT_TIMEOUT-1 and GNT_TIMEOUT!=0, set err_timeout and keep waiting. timer saturates.
//  GRANTED: gnt[owner_id] = ti_gnt (combinational pass-through). ti_req = req[owner_id].
//    If pr_done=1, pulse done[owner_id] and go to IDLE. This check has priority.
//    Else if req[owner_id]=0, go to WAIT_DONE.
//  WAIT_DONE: ti_req=0, gnt=0. On pr_done=1, pulse done[owner_id] and go to IDLE.
//  On every return to IDLE: rr_ptr = owner_id+1, wrapping to 0 after NUM_REQ-1. Clear timer.
//  Requests arriving or changing in non-IDLE states are ignored until IDLE. There is no preemption.
//  pr_done in IDLE or REQ is ignored and produces no done pulse.
//  The owner's req may drop and rise again in the same GRANTED cycle; only its level matters.
//  Simultaneous requests: the lowest index at or after rr_ptr wins.
//  NUM_REQ=1 degenerates to a pass-through with the same FSM; rr_ptr stays 0.
//  rst mid-operation returns to the reset values next cycle. The controller is reset by the same rst, so no handshake recovery is needed.
//  gnt is always one-hot or zero. done is asserted for exactly one cycle per transfer.
// STRUCTURE
//  Shared package ti_pkg: FSM state encoding localparams (IDLE..WAIT_DONE) and the clog2 helper function.
//  One sub-module, rr_pick: a combinational round-robin priority picker.
//    Inputs: req vector, rr_ptr. Outputs: valid, winner index.
//    Implemented with a double-width masked priority encoder.
//  The FSM, timer and output decode stay in ti_arbiter.
// TESTING
//  1. Single request: req=4'b0100 -> ti_req rises 1 cycle later. ti_gnt=1 -> gnt=4'b0100.
//     Drop req -> ti_req=0. pr_done -> done=4'b0100 for 1 cycle, busy=0, rr_ptr=3.
//  2. Fairness: req=4'b1111 held for 4 transfers from reset -> owners granted in order 0,1,2,3.
//  3. Early pr_done: pr_done pulses in GRANTED while owner req=1 -> done pulse, IDLE. Next owner selected on the following cycle.
//  4. Timeout: GNT_TIMEOUT=8, ti_gnt withheld -> err_timeout=1 after 8 REQ cycles, ti_req stays 1.
//     Later ti_gnt=1 -> normal grant. err_timeout stays 1.
//  5. Mid-operation reset: rst in WAIT_DONE -> next cycle all outputs are at reset values. A later pr_done produces no done pulse.
//  6. Late requester: req[1] rises while owner 3 is in WAIT_DONE -> no gnt[1] until after done[3]. Then owner=1 with rr_ptr wrapped to 0.

Source files
------------

// File: rtl/ti_pkg.sv
// Shared definitions for the TI-port arbiter: FSM encoding and width helper.
// Pure declarations; no latency or backpressure of its own.
package ti_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_REQ       = 2'd1;
  localparam logic [1:0] ST_GRANTED   = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    REQ       = ST_REQ,
    GRANTED   = ST_GRANTED,
    WAIT_DONE = ST_WAIT_DONE
  } state_t;

  // Ceiling log2 with a floor of 1 so single-entry indices still have a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ti_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr, wrapping.
// Zero latency; no backpressure, vld simply reflects any pending request.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] rr_ptr,
  output logic            vld,
  output logic [ID_W-1:0] winner
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] req_msk;

  // Lower copy masked below the pointer; the upper copy supplies the wrap-around.
  always_comb begin
    req_dbl = {req, req};
    req_msk = req_dbl;
    for (int i = 0; i < N; i++) begin
      if (i < int'(rr_ptr)) req_msk[i] = 1'b0;
    end
    vld    = |req;
    winner = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (req_msk[i]) winner = ID_W'(i % N);
    end
  end

endmodule

// File: rtl/ti_arbiter.sv
// Round-robin owner of the single ti_req/ti_gnt port, held until pr_done; 1-cycle req->ti_req.
// No preemption: new requests wait for IDLE; done is a registered one-cycle pulse after pr_done.
module ti_arbiter
  import ti_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = clog2(NUM_REQ),
  parameter int GNT_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic               ti_req,
  input  logic               ti_gnt,
  input  logic               pr_done,
  output logic               busy,
  output logic [ID_W-1:0]    owner_id,
  output logic               err_timeout
);

  localparam int                TMR_W   = clog2(GNT_TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_MAX = TMR_W'((GNT_TIMEOUT == 0) ? 0 : GNT_TIMEOUT - 1);
  localparam logic [ID_W-1:0]   LAST_ID = ID_W'(NUM_REQ - 1);

  state_t               state_q, state_d;
  logic [ID_W-1:0]      owner_q;
  logic [ID_W-1:0]      rr_ptr_q;
  logic [TMR_W-1:0]     timer_q;
  logic [NUM_REQ-1:0]   done_q;
  logic                 err_q;

  logic                 pick_vld;
  logic [ID_W-1:0]      pick_idx;
  logic [NUM_REQ-1:0]   owner_oh;
  logic                 owner_req;
  logic                 load_owner;
  logic                 finish;
  logic [ID_W-1:0]      rr_ptr_nxt;

  rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .vld    (pick_vld),
    .winner (pick_idx)
  );

  assign owner_oh   = NUM_REQ'(1) << owner_q;
  assign owner_req  = |(req & owner_oh);
  assign rr_ptr_nxt = (owner_q == LAST_ID) ? '0 : owner_q + ID_W'(1);

  always_comb begin
    state_d    = state_q;
    ti_req     = 1'b0;
    gnt        = '0;
    load_owner = 1'b0;
    finish     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          load_owner = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        // Held regardless of the owner's req: the controller needs it until grant.
        ti_req = 1'b1;
        if (ti_gnt) state_d = GRANTED;
      end
      GRANTED: begin
        gnt    = ti_gnt ? owner_oh : '0;
        ti_req = owner_req;
        if (pr_done) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else if (!owner_req) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (pr_done) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      timer_q  <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= finish ? owner_oh : '0;
      if (load_owner) owner_q <= pick_idx;
      if (finish) rr_ptr_q <= rr_ptr_nxt;

      if (state_q == IDLE) begin
        timer_q <= '0;
      end else if (state_q == REQ && timer_q != TMR_MAX) begin
        timer_q <= timer_q + TMR_W'(1);
      end

      // Grant landing on the last allowed cycle is still in time.
      if (GNT_TIMEOUT != 0 && state_q == REQ && !ti_gnt && timer_q == TMR_MAX) begin
        err_q <= 1'b1;
      end
    end
  end

  assign done        = done_q;
  assign busy        = (state_q != IDLE);
  assign owner_id    = owner_q;
  assign err_timeout = err_q;

endmodule
